// File: rtl/ena_sched_pkg.sv
// Shared types and constants for the ena scheduler.
// Optional pseudo-random selection is enabled with ENA_SCHED_RANDOM_EN.
package ena_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EVAL = 2'd1,
    ST_FIRE = 2'd2,
    ST_DEAD = 2'd3
  } sched_state_e;

  // Fibonacci taps 16, 14, 13, 11 (bit 15 is tap 16)
  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  function automatic int IDX_W(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/ena_scheduler_rot_pick.sv
// Rotating-priority finder: first set bit of vec_i at or above start_i, wrapping N-1 -> 0.
module rot_pick #(
  parameter int N  = 8,
  parameter int IW = 3
) (
  input  logic [N-1:0]  vec_i,
  input  logic [IW-1:0] start_i,
  output logic          found_o,
  output logic [IW-1:0] idx_o
);

  logic [IW-1:0] cand_s;

  // Scan from the far end backwards so the lowest rotated offset wins
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    cand_s  = '0;
    for (int i = N - 1; i >= 0; i--) begin
      cand_s = IW'((int'(start_i) + i) % N);
      if (vec_i[cand_s]) begin
        found_o = 1'b1;
        idx_o   = cand_s;
      end else begin
        found_o = found_o;
      end
    end
  end

endmodule

// File: rtl/ena_scheduler.sv
// Fires exactly one excited signal per step of a generated circuit model.
// Define ENA_SCHED_RANDOM_EN for LFSR-driven search start instead of round-robin.
module ena_scheduler
  import ena_sched_pkg::*;
#(
  parameter int          N              = 8,
  parameter int          N_IN           = 2,
  parameter int          DEADLOCK_LIMIT = 4,
  parameter logic [15:0] SEED           = DEFAULT_SEED
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  run,
  input  logic [N-1:0]          excited,
  input  logic                  env_en,
  output logic [N-1:0]          ena,
  output logic                  fire_valid,
  output logic [IDX_W(N)-1:0]   fire_idx,
  output logic                  deadlock,
  output logic [31:0]           step_count
);

  localparam int IW = IDX_W(N);
  localparam int QW = IDX_W(DEADLOCK_LIMIT + 1);

  sched_state_e  state_q, state_d;
  logic [N-1:0]  ena_q, ena_d;
  logic          fire_valid_q, fire_valid_d;
  logic [IW-1:0] fire_idx_q, fire_idx_d;
  logic          deadlock_q, deadlock_d;
  logic [31:0]   step_count_q, step_count_d;
  logic [QW-1:0] quiet_q, quiet_d;

  logic [N-1:0]  elig_s;
  logic [IW-1:0] start_s;
  logic          pick_found_s;
  logic [IW-1:0] pick_idx_s;
  logic          fire_s;

  assign elig_s = excited & {{(N - N_IN){1'b1}}, {N_IN{env_en}}};
  assign fire_s = (state_q == ST_EVAL) && run && pick_found_s;

  rot_pick #(.N(N), .IW(IW)) u_pick (
    .vec_i   (elig_s),
    .start_i (start_s),
    .found_o (pick_found_s),
    .idx_o   (pick_idx_s)
  );

`ifdef ENA_SCHED_RANDOM_EN
  logic [15:0] lfsr_q, lfsr_d;

  assign start_s = IW'(int'(lfsr_q[IW-1:0]) % N);
  assign lfsr_d  = (state_q == ST_EVAL) ? lfsr_next(lfsr_q) : lfsr_q;

  // LFSR advances once per EVAL cycle, fired or not
  always_ff @(posedge clk or posedge reset) begin
    if (reset) lfsr_q <= SEED;
    else       lfsr_q <= lfsr_d;
  end
`else
  logic [IW-1:0] rr_q, rr_d;
  logic          unused_seed_s;

  assign unused_seed_s = ^SEED;
  assign start_s       = rr_q;
  assign rr_d          = !fire_s ? rr_q :
                         (pick_idx_s == IW'(N - 1)) ? '0 : pick_idx_s + 1'b1;

  // Round-robin pointer moves just past the bit that fired
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rr_q <= '0;
    else       rr_q <= rr_d;
  end
`endif

  // Next-state and registered-output logic
  always_comb begin
    state_d      = state_q;
    ena_d        = '0;
    fire_valid_d = 1'b0;
    fire_idx_d   = fire_idx_q;
    deadlock_d   = deadlock_q;
    step_count_d = step_count_q;
    quiet_d      = quiet_q;
    case (state_q)
      ST_IDLE: begin
        if (run) state_d = ST_EVAL;
        else     state_d = ST_IDLE;
      end
      ST_EVAL: begin
        if (!run) begin
          state_d = ST_IDLE;
        end else if (pick_found_s) begin
          ena_d        = N'(1) << pick_idx_s;
          fire_valid_d = 1'b1;
          fire_idx_d   = pick_idx_s;
          quiet_d      = '0;
          state_d      = ST_FIRE;
        end else if (quiet_q == QW'(DEADLOCK_LIMIT - 1)) begin
          quiet_d    = QW'(DEADLOCK_LIMIT);
          deadlock_d = 1'b1;
          state_d    = ST_DEAD;
        end else begin
          quiet_d = quiet_q + 1'b1;
        end
      end
      ST_FIRE: begin
        step_count_d = (step_count_q == 32'hFFFF_FFFF) ? step_count_q : step_count_q + 32'd1;
        if (run) state_d = ST_EVAL;
        else     state_d = ST_IDLE;
      end
      ST_DEAD: begin
        deadlock_d = 1'b1;
        state_d    = ST_DEAD;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      ena_q        <= '0;
      fire_valid_q <= 1'b0;
      fire_idx_q   <= '0;
      deadlock_q   <= 1'b0;
      step_count_q <= 32'd0;
      quiet_q      <= '0;
    end else begin
      state_q      <= state_d;
      ena_q        <= ena_d;
      fire_valid_q <= fire_valid_d;
      fire_idx_q   <= fire_idx_d;
      deadlock_q   <= deadlock_d;
      step_count_q <= step_count_d;
      quiet_q      <= quiet_d;
    end
  end

  assign ena        = ena_q;
  assign fire_valid = fire_valid_q;
  assign fire_idx   = fire_idx_q;
  assign deadlock   = deadlock_q;
  assign step_count = step_count_q;

endmodule

// File: tb/tb_ena_scheduler.sv
// Scoreboard bench for ena_scheduler (N=4, N_IN=1, DEADLOCK_LIMIT=4).
module tb_ena_scheduler;

  logic        clk;
  logic        reset;
  logic        run;
  logic [3:0]  excited;
  logic        env_en;
  logic [3:0]  ena;
  logic        fire_valid;
  logic [1:0]  fire_idx;
  logic        deadlock;
  logic [31:0] step_count;

  int n_vec;
  int n_err;
  int exp_q[$];
  int tb_ptr;
  int tb_steps;

  ena_scheduler #(
    .N(4), .N_IN(1), .DEADLOCK_LIMIT(4), .SEED(16'hACE1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .excited    (excited),
    .env_en     (env_en),
    .ena        (ena),
    .fire_valid (fire_valid),
    .fire_idx   (fire_idx),
    .deadlock   (deadlock),
    .step_count (step_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int model_pick(input logic [3:0] elig, input int start);
    for (int i = 0; i < 4; i++) begin
      if (elig[(start + i) % 4]) return (start + i) % 4;
    end
    return -1;
  endfunction

  task automatic do_reset();
    reset = 1'b1; run = 1'b0; excited = 4'b0000; env_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    tb_ptr = 0; tb_steps = 0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1; run = 1'b1; excited = 4'b1111; env_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_vec++; if (ena !== 4'b0000)       begin n_err++; $display("FAIL reset_ena got=%b exp=0000", ena); end
    n_vec++; if (fire_valid !== 1'b0)   begin n_err++; $display("FAIL reset_fv got=%b exp=0", fire_valid); end
    n_vec++; if (fire_idx !== 2'd0)     begin n_err++; $display("FAIL reset_idx got=%0d exp=0", fire_idx); end
    n_vec++; if (deadlock !== 1'b0)     begin n_err++; $display("FAIL reset_dl got=%b exp=0", deadlock); end
    n_vec++; if (step_count !== 32'd0)  begin n_err++; $display("FAIL reset_steps got=%0d exp=0", step_count); end
  endtask

  // Expected picks are pushed up front, then popped as the DUT fires.
  task automatic test_round_robin(input logic [3:0] exc, input logic en, input int nfires);
    logic [3:0] elig;
    logic       prev_fv;
    int         k;
    int         budget;
    excited = exc; env_en = en;
    elig = exc & {3'b111, en};
    for (int n = 0; n < nfires; n++) begin
      k = model_pick(elig, tb_ptr);
      exp_q.push_back(k);
      tb_ptr = (k + 1) % 4;
    end
    run = 1'b1; prev_fv = 1'b0; budget = 4 * nfires + 6;
    while (exp_q.size() > 0 && budget > 0) begin
      @(negedge clk);
      budget--;
      if (fire_valid) begin
        k = exp_q.pop_front();
        n_vec++;
        if (fire_idx !== 2'(k) || ena !== (4'b0001 << k)) begin
          n_err++; $display("FAIL rr_pick exc=%b got idx=%0d ena=%b exp idx=%0d", exc, fire_idx, ena, k);
        end
        n_vec++; if (prev_fv) begin n_err++; $display("FAIL rr_throughput fires on consecutive cycles exc=%b", exc); end
        tb_steps++;
        if (exp_q.size() == 0) run = 1'b0;
      end else begin
        n_vec++; if (ena !== 4'b0000) begin n_err++; $display("FAIL rr_idle_ena got=%b exp=0000", ena); end
      end
      prev_fv = fire_valid;
    end
    if (exp_q.size() > 0) begin
      n_vec++; n_err++; $display("FAIL rr_timeout exc=%b %0d fires missing", exc, exp_q.size());
      exp_q.delete();
    end
    run = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_vec++; if (step_count !== 32'(tb_steps)) begin n_err++; $display("FAIL rr_steps got=%0d exp=%0d", step_count, tb_steps); end
  endtask

  task automatic test_deadlock();
    do_reset();
    excited = 4'b0001; env_en = 1'b0; run = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      n_vec++; if (deadlock !== 1'(c >= 5)) begin n_err++; $display("FAIL dl_onset cyc=%0d got=%b exp=%b", c, deadlock, c >= 5); end
      n_vec++; if (ena !== 4'b0000) begin n_err++; $display("FAIL dl_ena cyc=%0d got=%b exp=0000", c, ena); end
    end
    excited = 4'b1111; env_en = 1'b1;
    for (int c = 0; c < 8; c++) begin
      run = c[1];
      @(negedge clk);
      n_vec++; if (deadlock !== 1'b1 || ena !== 4'b0000 || fire_valid !== 1'b0) begin
        n_err++; $display("FAIL dl_sticky cyc=%0d got dl=%b ena=%b fv=%b exp dl=1 ena=0000 fv=0", c, deadlock, ena, fire_valid);
      end
    end
    reset = 1'b1;
    #1;
    n_vec++; if (deadlock !== 1'b0) begin n_err++; $display("FAIL dl_clear got=%b exp=0", deadlock); end
    @(negedge clk);
    reset = 1'b0; run = 1'b0;
  endtask

  task automatic test_run_drop();
    int budget;
    do_reset();
    excited = 4'b0100; env_en = 1'b1; run = 1'b1;
    budget = 10;
    do begin @(negedge clk); budget--; end while (!fire_valid && budget > 0);
    n_vec++; if (ena !== 4'b0100) begin n_err++; $display("FAIL drop_pulse got=%b exp=0100", ena); end
    run = 1'b0;
    excited = 4'b1000;
    @(negedge clk);
    n_vec++; if (ena !== 4'b0000 || fire_valid !== 1'b0) begin
      n_err++; $display("FAIL drop_end got ena=%b fv=%b exp ena=0000 fv=0", ena, fire_valid);
    end
    excited = 4'b0100;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_vec++; if (ena !== 4'b0000) begin n_err++; $display("FAIL drop_idle cyc=%0d got=%b exp=0000", c, ena); end
    end
    run = 1'b1;
    @(negedge clk);
    n_vec++; if (fire_valid !== 1'b0) begin n_err++; $display("FAIL drop_eval got fv=%b exp=0", fire_valid); end
    @(negedge clk);
    n_vec++; if (fire_valid !== 1'b1 || ena !== 4'b0100) begin
      n_err++; $display("FAIL drop_resume got fv=%b ena=%b exp fv=1 ena=0100", fire_valid, ena);
    end
    run = 1'b0;
    @(negedge clk);
    n_vec++; if (step_count !== 32'd2) begin n_err++; $display("FAIL drop_steps got=%0d exp=2", step_count); end
  endtask

  task automatic test_async_reset();
    int budget;
    int fires;
    do_reset();
    excited = 4'b0100; env_en = 1'b1; run = 1'b1;
    budget = 12; fires = 0;
    while (fires < 2 && budget > 0) begin
      @(negedge clk); budget--;
      if (fire_valid) fires++;
    end
    n_vec++; if (fires != 2 || step_count !== 32'd1) begin
      n_err++; $display("FAIL arst_setup got fires=%0d steps=%0d exp fires=2 steps=1", fires, step_count);
    end
    #2 reset = 1'b1;
    #1;
    n_vec++; if (ena !== 4'b0000 || fire_valid !== 1'b0 || step_count !== 32'd0) begin
      n_err++; $display("FAIL arst_midfire got ena=%b fv=%b steps=%0d exp 0000/0/0", ena, fire_valid, step_count);
    end
    @(negedge clk);
    reset = 1'b0; run = 1'b0;
  endtask

  task automatic test_saturation();
    int budget;
    do_reset();
    @(negedge clk);
    force dut.step_count_q = 32'hFFFF_FFFE;
    @(negedge clk);
    release dut.step_count_q;
    n_vec++; if (step_count !== 32'hFFFF_FFFE) begin n_err++; $display("FAIL sat_preload got=%h exp=fffffffe", step_count); end
    excited = 4'b0100; env_en = 1'b1; run = 1'b1;
    for (int f = 0; f < 2; f++) begin
      budget = 10;
      do begin @(negedge clk); budget--; end while (!fire_valid && budget > 0);
      @(negedge clk);
      n_vec++; if (step_count !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL sat_fire%0d got=%h exp=ffffffff", f, step_count); end
    end
    run = 1'b0;
    @(negedge clk);
  endtask

`ifdef ENA_SCHED_RANDOM_EN
  task automatic test_random();
    logic [15:0] l;
    int          first_run[$];
    int          k;
    int          budget;
    for (int rep = 0; rep < 2; rep++) begin
      do_reset();
      l = 16'hACE1;
      for (int s = 0; s < 16; s++) begin
        exp_q.push_back(int'(l[1:0]));
        if (rep == 0) first_run.push_back(int'(l[1:0]));
        l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
      end
      excited = 4'b1111; env_en = 1'b1; run = 1'b1;
      budget = 60;
      while (exp_q.size() > 0 && budget > 0) begin
        @(negedge clk); budget--;
        if (fire_valid) begin
          k = exp_q.pop_front();
          n_vec++; if (fire_idx !== 2'(k)) begin n_err++; $display("FAIL rnd_pick rep=%0d got=%0d exp=%0d", rep, fire_idx, k); end
          if (rep == 1) begin
            n_vec++; if (fire_idx !== 2'(first_run[15 - exp_q.size()])) begin
              n_err++; $display("FAIL rnd_repeat got=%0d exp=%0d", fire_idx, first_run[15 - exp_q.size()]);
            end
          end
        end
      end
      if (exp_q.size() > 0) begin
        n_vec++; n_err++; $display("FAIL rnd_timeout rep=%0d %0d fires missing", rep, exp_q.size());
        exp_q.delete();
      end
      run = 1'b0;
      @(negedge clk);
    end
  endtask
`endif

  initial begin
    n_vec = 0; n_err = 0; tb_ptr = 0; tb_steps = 0;
    reset = 1'b1; run = 1'b0; excited = 4'b0000; env_en = 1'b0;
    test_reset();
`ifdef ENA_SCHED_RANDOM_EN
    test_random();
`else
    do_reset();
    test_round_robin(4'b1010, 1'b1, 3);
    test_round_robin(4'b1111, 1'b0, 5);
    test_round_robin(4'b0100, 1'b1, 2);
    test_round_robin(4'b0011, 1'b1, 3);
    test_round_robin(4'b0011, 1'b0, 1);
`endif
    test_deadlock();
    test_run_drop();
    test_async_reset();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
